// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for serial_adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int chunks(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  function automatic bit bpc_divides(input int width, input int bits_per_cycle);
    return (bits_per_cycle > 0) && (width % bits_per_cycle == 0);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; chained BITS_PER_CYCLE times to form the ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Start/done sequential adder: BITS_PER_CYCLE bits per clock, result after WIDTH/BITS_PER_CYCLE cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A-B via inverted B and carry-in 1).
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int N     = chunks(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = (N > 1) ? WIDTH - BPC : 1;

  if (!bpc_divides(WIDTH, BITS_PER_CYCLE) || WIDTH < 2) begin : g_param_check
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end

  logic sub_sel;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cin_q, cin_d;
  logic               a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [BPC:0]       c;
  logic [BPC-1:0]     slice_sum;
  logic [ACC_W-1:0]   acc_shift;
  logic [WIDTH-1:0]   sum_full;

  assign c[0] = cin_q;
  for (genvar i = 0; i < BPC; i++) begin : g_slice
    full_adder u_fa (
      .a   (a_q[i]),
      .b   (b_q[i]),
      .cin (c[i]),
      .sum (slice_sum[i]),
      .cout(c[i+1])
    );
  end

  // acc holds the first N-1 chunks; the final chunk goes straight into sum.
  if (N == 1) begin : g_acc_none
    assign acc_shift = '0;
    assign sum_full  = slice_sum;
  end else if (N == 2) begin : g_acc_one
    assign acc_shift = slice_sum;
    assign sum_full  = {slice_sum, acc_q};
  end else begin : g_acc_shift
    assign acc_shift = {slice_sum, acc_q[ACC_W-1:BPC]};
    assign sum_full  = {slice_sum, acc_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub_sel ? ~b : b;
          acc_d   = '0;
          cnt_d   = '0;
          cin_d   = sub_sel;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1] ^ sub_sel;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> BPC;
        b_d   = b_q >> BPC;
        acc_d = acc_shift;
        cin_d = c[BPC];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          sum_d   = sum_full;
          carry_d = c[BPC];
          ovf_d   = (a_msb_q == b_msb_q) && (sum_full[WIDTH-1] != a_msb_q);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, clocked multi-bit adder built on a `full_adder` sub-module. It is the sequential successor to the team's combinational half/full adders. A start/done handshake captures two WIDTH-bit operands. The block adds them `BITS_PER_CYCLE` bits per clock through a ripple slice and returns a registered sum, carry-out and signed overflow. It sits between control logic issuing one-shot arithmetic requests and narrow datapaths where a full-width combinational adder is too large.

## Interface
- `WIDTH`, 8: operand and sum width; ≥2.
- `BITS_PER_CYCLE`, 1: bits processed per clock; must divide `WIDTH` (elaboration error otherwise).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only while `ready`=1.
- `a`  in  WIDTH  operand A; sampled on the accepting edge only.
- `b`  in  WIDTH  operand B; sampled on the accepting edge only.
- `sub`  in  1  1 = A−B, 0 = A+B; present only with `SERIAL_ADDER_SUB_EN`.
- `ready`  out  1  high in IDLE.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `sum`  out  WIDTH  registered result.
- `carry`  out  1  carry-out; in subtract mode 1 = no borrow (A ≥ B unsigned).
- `overflow`  out  1  two's-complement signed overflow.

## Operation
- N = WIDTH/BITS_PER_CYCLE chunks. FSM states: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - capture `a` → shift register A and `b` (inverted when subtracting) → shift register B;
  - carry register ← 0 for add, 1 for subtract; chunk counter ← 0; go to RUN.
- RUN, each edge:
  - low `BITS_PER_CYCLE` bits of A, B and the carry pass through the ripple slice;
  - the result chunk enters the sum shift register from the MSB side; A and B shift right by `BITS_PER_CYCLE`;
  - the carry register takes the slice carry-out and the counter increments.
  - On the edge processing chunk N−1: load `sum`/`carry`/`overflow` output registers and go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` in RUN or DONE is ignored; no queuing.
- Outputs `sum`/`carry`/`overflow` change only at the final RUN edge or at reset. They hold their value through IDLE and the next RUN.
- Overflow = (A_msb == B'_msb) && (result_msb != A_msb), where B' is the possibly inverted B. Both MSBs are captured at acceptance.
- Arithmetic is modulo 2^WIDTH; the carry register is 1 bit; the counter is ⌈log2 N⌉ bits and wraps only through reset/restart.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; `ready`=1; `busy`=0; `done`=0; `sum`=0; `carry`=0; `overflow`=0; all internal registers 0.
- The accepting edge is E0. RUN occupies edges E1..EN. Outputs are valid and `done`=1 from EN until E(N+1). `ready`=1 again after E(N+1).
- Latency from acceptance to `done` is N cycles; throughput is one operation per N+2 cycles.
- `ready`, `busy` and `done` decode directly from the state register; there is no combinational path from inputs to outputs.
- `rst_n` asserted mid-RUN or mid-DONE: immediate return to IDLE with all outputs cleared. The partial result is discarded and no `done` pulse is issued.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined: the `sub` port exists and selects B inversion with carry-in 1 per the rules above.
- `SERIAL_ADDER_SUB_EN` undefined: no `sub` port; the block is add-only with B uninverted and carry-in 0. Result for `sub`=0 is cycle-identical in both builds.

## Structure
- Package `adder_pkg` holds:
  - the state enum `{IDLE, RUN, DONE}`;
  - the `chunks(WIDTH, BITS_PER_CYCLE)` constant function;
  - the `BITS_PER_CYCLE`-divides-`WIDTH` check.
- Sub-module `full_adder` (a, b, cin → sum, cout). It is instantiated `BITS_PER_CYCLE` times in a generate loop to form the ripple slice.

## Test plan
- WIDTH=8, BPC=1: A=0x0F, B=0x01 → `sum`=0x10, `carry`=0, `overflow`=0. `done` is exactly 8 edges after acceptance and lasts 1 cycle.
- A=0xFF, B=0x01 → `sum`=0x00, `carry`=1, `overflow`=0. Then A=0x7F, B=0x01 → `sum`=0x80, `carry`=0, `overflow`=1.
- `SERIAL_ADDER_SUB_EN`, `sub`=1: A=0x05, B=0x07 → `sum`=0xFE, `carry`=0. Then A=0x80, B=0x01 → `sum`=0x7F, `carry`=1, `overflow`=1.
- Pulse `start` with new operands mid-RUN and during DONE → ignored; the first result is unchanged, and after `ready` returns `start` is accepted normally.
- Assert `rst_n`=0 at RUN cycle 4 → same cycle: `busy`=0, `ready`=1, `sum`=0. No `done` pulse; the next operation completes correctly.
- WIDTH=8, BPC=4: A=0x9C, B=0x64 → `sum`=0x00, `carry`=1, `overflow`=0. `done` is 2 edges after acceptance.
